multi_sync_edge: RTL and testbench



---
 rtl/multi_sync_pkg.sv | 26 ++
 rtl/sync_filt_ch.sv | 96 +++++++++
 rtl/multi_sync_edge.sv | 46 ++++
 tb/tb_multi_sync_edge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_sync_pkg.sv
// Shared edge-mode encodings and sizing helpers for the multi-channel input conditioner.
package multi_sync_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // The counter must hold FILT_CYC-1; one bit minimum keeps FILT_CYC=1 legal.
  function automatic int cntWidth(input int filtCyc);
    return (filtCyc < 1) ? 1 : $clog2(filtCyc + 1);
  endfunction

  function automatic logic edgeHit(input logic [1:0] mode, input logic newLevel);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = newLevel;
      EDGE_FALL: hit = !newLevel;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: synchronizer chain, stability filter, edge detector and sticky flag.
// Sticky flag flops exist only when MULTI_SYNC_STICKY_EN is defined.
module sync_filt_ch
  import multi_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_i,
  input  logic [1:0] mode_i,
  input  logic       evt_clr_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       evt_o
);

  localparam int CW = cntWidth(FILT_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   syncS;

  assign syncS = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

  // The level only moves after FILT_CYC consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (syncS == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILT_CYC - 1)) begin
      level_d = syncS;
      cnt_d   = '0;
      pulse_d = edgeHit(mode_i, syncS);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

`ifdef MULTI_SYNC_STICKY_EN
  logic evt_q, evt_d;

  // A pulse visible this cycle outranks a simultaneous clear.
  always_comb begin
    evt_d = evt_q;
    if (pulse_q) begin
      evt_d = 1'b1;
    end else if (evt_clr_i) begin
      evt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_o = evt_q;
`else
  logic unusedClr;
  assign unusedClr = evt_clr_i;
  assign evt_o     = 1'b0;
`endif

endmodule

// File: rtl/multi_sync_edge.sv
// Multi-channel conditioner for asynchronous single-bit inputs: CH independent sync/filter/edge channels.
// Define MULTI_SYNC_STICKY_EN to build the per-channel sticky event flags.
module multi_sync_edge
  import multi_sync_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   sig_i,
  input  logic [2*CH-1:0] mode_i,
  input  logic [CH-1:0]   evt_clr_i,
  output logic [CH-1:0]   level_o,
  output logic [CH-1:0]   pulse_o,
  output logic [CH-1:0]   evt_o
);

  if (CH < 1) begin : gen_bad_ch
    $fatal(1, "multi_sync_edge: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : gen_bad_sync
    $fatal(1, "multi_sync_edge: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYC < 1) begin : gen_bad_filt
    $fatal(1, "multi_sync_edge: FILT_CYC must be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : gen_ch
    sync_filt_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYC   (FILT_CYC)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sig_i    (sig_i[i]),
      .mode_i   (mode_i[2*i +: 2]),
      .evt_clr_i(evt_clr_i[i]),
      .level_o  (level_o[i]),
      .pulse_o  (pulse_o[i]),
      .evt_o    (evt_o[i])
    );
  end

endmodule

// File: tb/tb_multi_sync_edge.sv
// Directed self-checking bench for multi_sync_edge (CH=4, SYNC_STAGES=2, FILT_CYC=4).
// Sticky-flag expectations follow whether MULTI_SYNC_STICKY_EN is defined.
module tb_multi_sync_edge;

`ifdef MULTI_SYNC_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] sig_i;
  logic [7:0] mode_i;
  logic [3:0] evt_clr_i;
  logic [3:0] level_o;
  logic [3:0] pulse_o;
  logic [3:0] evt_o;

  int passCnt;
  int checkCnt;

  multi_sync_edge #(
    .CH         (4),
    .SYNC_STAGES(2),
    .FILT_CYC   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (sig_i),
    .mode_i   (mode_i),
    .evt_clr_i(evt_clr_i),
    .level_o  (level_o),
    .pulse_o  (pulse_o),
    .evt_o    (evt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] sig, input logic [7:0] mode,
                               input logic [3:0] clr, input logic r);
    sig_i     = sig;
    mode_i    = mode;
    evt_clr_i = clr;
    rst       = r;
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCnt = checkCnt + 1;
    assert (observed === expected) passCnt = passCnt + 1;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic resetDut(input logic [7:0] mode);
    applyStimulus(4'h0, mode, 4'h0, 1'b1);
    waitEdges(2);
    rst = 1'b0;
  endtask

  // Drives ch2 high for 10 edges then low, over 24 edges, recording pulses on ch2.
  task automatic runToggle(input logic [7:0] mode, output int count, output int firstEdge,
                           output logic lvl6, output logic lvl16);
    count     = 0;
    firstEdge = 0;
    lvl6      = 1'b0;
    lvl16     = 1'b1;
    mode_i    = mode;
    for (int e = 1; e <= 24; e++) begin
      if (e == 1)  sig_i[2] = 1'b1;
      if (e == 11) sig_i[2] = 1'b0;
      waitEdges(1);
      if (pulse_o[2]) begin
        count = count + 1;
        if (firstEdge == 0) firstEdge = e;
      end
      if (e == 6)  lvl6  = level_o[2];
      if (e == 16) lvl16 = level_o[2];
    end
  endtask

  initial begin
    int   cnt;
    int   firstE;
    logic l6;
    logic l16;
    int   off[4];
    logic [3:0] expLevel;
    logic [3:0] expPulse;
    logic [7:0] idleModes[4];

    passCnt  = 0;
    checkCnt = 0;
    off       = '{0, 1, 3, 7};
    idleModes = '{8'hFF, 8'h55, 8'hAA, 8'h00};

    $display("[TB] reset with inputs high, then rise on all channels");
    applyStimulus(4'hF, 8'h55, 4'h0, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      waitEdges(1);
      checkOutput("rst_level", level_o, 4'h0);
      checkOutput("rst_pulse", pulse_o, 4'h0);
      checkOutput("rst_evt", evt_o, 4'h0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      waitEdges(1);
      checkOutput("t1_level", level_o, (e >= 6) ? 4'hF : 4'h0);
      checkOutput("t1_pulse", pulse_o, (e == 6) ? 4'hF : 4'h0);
      checkOutput("t1_evt", evt_o, (STICKY && e >= 7) ? 4'hF : 4'h0);
    end

    $display("[TB] glitch filter on ch1");
    resetDut(8'h55);
    checkOutput("t2_evt_after_rst", evt_o, 4'h0);
    sig_i = 4'b0010;
    for (int e = 1; e <= 10; e++) begin
      waitEdges(1);
      if (e == 3) sig_i = 4'b0000;
      checkOutput("t2_glitch_level", level_o, 4'h0);
      checkOutput("t2_glitch_pulse", pulse_o, 4'h0);
    end
    sig_i = 4'b0010;
    for (int e = 1; e <= 11; e++) begin
      waitEdges(1);
      if (e == 4) sig_i = 4'b0000;
      checkOutput("t2_level", level_o, (e >= 6 && e < 10) ? 4'b0010 : 4'b0000);
      checkOutput("t2_pulse", pulse_o, (e == 6) ? 4'b0010 : 4'b0000);
    end

    $display("[TB] edge modes on ch2");
    resetDut(8'h00);
    runToggle(8'h20, cnt, firstE, l6, l16);
    checkOutput("t3_fall_count", cnt, 1);
    checkOutput("t3_fall_edge", firstE, 16);
    checkOutput("t3_fall_lvl6", l6, 1'b1);
    checkOutput("t3_fall_lvl16", l16, 1'b0);
    runToggle(8'h30, cnt, firstE, l6, l16);
    checkOutput("t3_both_count", cnt, 2);
    checkOutput("t3_both_first", firstE, 6);
    runToggle(8'h00, cnt, firstE, l6, l16);
    checkOutput("t3_off_count", cnt, 0);
    checkOutput("t3_off_lvl6", l6, 1'b1);
    checkOutput("t3_off_lvl16", l16, 1'b0);
    for (int m = 0; m < 4; m++) begin
      mode_i = idleModes[m];
      for (int e = 0; e < 2; e++) begin
        waitEdges(1);
        checkOutput("t3_idle_mode_pulse", pulse_o, 4'h0);
      end
    end

    $display("[TB] sticky flags on ch3");
    resetDut(8'hC0);
    sig_i = 4'b1000;
    for (int e = 1; e <= 20; e++) begin
      waitEdges(1);
      checkOutput("t4_level", level_o, (e >= 6 && e < 16) ? 4'b1000 : 4'b0000);
      checkOutput("t4_pulse", pulse_o, (e == 6 || e == 16) ? 4'b1000 : 4'b0000);
      checkOutput("t4_evt", evt_o, (STICKY && e >= 7 && e <= 18) ? 4'b1000 : 4'b0000);
      if (e == 10) sig_i = 4'b0000;
      if (e == 16) evt_clr_i = 4'b1000;
      if (e == 17) evt_clr_i = 4'b0000;
      if (e == 18) evt_clr_i = 4'b1000;
      if (e == 19) evt_clr_i = 4'b0000;
    end

    $display("[TB] reset in the middle of filtering on ch0");
    resetDut(8'h01);
    sig_i = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      waitEdges(1);
      checkOutput("t5_pre_level", level_o, 4'h0);
    end
    rst = 1'b1;
    waitEdges(1);
    checkOutput("t5_rst_level", level_o, 4'h0);
    checkOutput("t5_rst_pulse", pulse_o, 4'h0);
    rst = 1'b0;
    for (int e = 6; e <= 12; e++) begin
      waitEdges(1);
      checkOutput("t5_level", level_o, (e >= 11) ? 4'b0001 : 4'b0000);
      checkOutput("t5_pulse", pulse_o, (e == 11) ? 4'b0001 : 4'b0000);
    end

    $display("[TB] staggered channels");
    resetDut(8'h55);
    for (int e = 1; e <= 16; e++) begin
      for (int i = 0; i < 4; i++) begin
        if (e >= off[i] + 1) sig_i[i] = 1'b1;
      end
      waitEdges(1);
      for (int i = 0; i < 4; i++) begin
        expLevel[i] = (e >= off[i] + 6);
        expPulse[i] = (e == off[i] + 6);
      end
      checkOutput("t6_level", level_o, expLevel);
      checkOutput("t6_pulse", pulse_o, expPulse);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
